// File: rtl/rank9_pipe.sv
// rank9_pipe: three-stage 3x3 rank filter (min/median/max) with valid/ready flow control.
// Row sort, then column-wise reduction, then final median pick and mode select.
module rank9_pipe #(
    parameter int WIDTH  = 9,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] x_0,
    input  logic [WIDTH-1:0] x_1,
    input  logic [WIDTH-1:0] x_2,
    input  logic [WIDTH-1:0] x_3,
    input  logic [WIDTH-1:0] x_4,
    input  logic [WIDTH-1:0] x_5,
    input  logic [WIDTH-1:0] x_6,
    input  logic [WIDTH-1:0] x_7,
    input  logic [WIDTH-1:0] x_8,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode
);
    typedef logic [WIDTH-1:0] w_t;

    function automatic logic lt(input w_t a, input w_t b);
        return SIGNED ? ($signed(a) < $signed(b)) : (a < b);
    endfunction

    function automatic w_t mn2(input w_t a, input w_t b);
        return lt(a, b) ? a : b;
    endfunction

    function automatic w_t mx2(input w_t a, input w_t b);
        return lt(a, b) ? b : a;
    endfunction

    function automatic w_t min3(input w_t a, input w_t b, input w_t c);
        return mn2(mn2(a, b), c);
    endfunction

    function automatic w_t max3(input w_t a, input w_t b, input w_t c);
        return mx2(mx2(a, b), c);
    endfunction

    function automatic w_t med3(input w_t a, input w_t b, input w_t c);
        return mx2(mn2(a, b), mn2(mx2(a, b), c));
    endfunction

    logic [8:0][WIDTH-1:0] x, s1_d, s1_q;
    logic [4:0][WIDTH-1:0] s2_d, s2_q;
    logic [1:0]            m1_q, m2_q, mode_q;
    logic                  v1_q, v2_q, v3_q, rdy1, rdy2, rdy3;
    w_t                    med, data_d, data_q;

    assign x = {x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0};

    assign rdy3     = !v3_q || out_ready;
    assign rdy2     = !v2_q || rdy3;
    assign rdy1     = !v1_q || rdy2;
    assign in_ready = rdy1;

    // s1 layout per row r: [3r]=lo, [3r+1]=mid, [3r+2]=hi
    always_comb begin
        s1_d = '0;
        for (int r = 0; r < 3; r++) begin
            s1_d[3*r]   = min3(x[3*r], x[3*r+1], x[3*r+2]);
            s1_d[3*r+1] = med3(x[3*r], x[3*r+1], x[3*r+2]);
            s1_d[3*r+2] = max3(x[3*r], x[3*r+1], x[3*r+2]);
        end
    end

    // s2 layout: A, B, C, MN, MX
    always_comb begin
        s2_d    = '0;
        s2_d[0] = max3(s1_q[0], s1_q[3], s1_q[6]);
        s2_d[1] = med3(s1_q[1], s1_q[4], s1_q[7]);
        s2_d[2] = min3(s1_q[2], s1_q[5], s1_q[8]);
        s2_d[3] = min3(s1_q[0], s1_q[3], s1_q[6]);
        s2_d[4] = max3(s1_q[2], s1_q[5], s1_q[8]);
    end

    assign med    = med3(s2_q[0], s2_q[1], s2_q[2]);
    assign data_d = (m2_q == 2'b00) ? s2_q[3] : (m2_q == 2'b10) ? s2_q[4] : med;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
            m1_q   <= 2'b00;
            m2_q   <= 2'b00;
            mode_q <= 2'b00;
            data_q <= '0;
        end else begin
            if (rdy1) begin
                v1_q <= in_valid;
                s1_q <= s1_d;
                m1_q <= in_mode;
            end
            if (rdy2) begin
                v2_q <= v1_q;
                s2_q <= s2_d;
                m2_q <= m1_q;
            end
            if (rdy3) begin
                v3_q   <= v2_q;
                data_q <= data_d;
                mode_q <= m2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;
endmodule
